// File: rtl/vec_feature_if.sv
// vec_feature_if: vector capture inputs plus byte-stream valid/ready output bundle
interface vec_feature_if #(parameter int ELEM_W = 8, parameter int N_ELEM = 20);
  logic [ELEM_W*N_ELEM-1:0] vec_feature;
  logic                     vec_feature_v;
  logic [1:0]               vec_mode;
  logic [7:0]               n_pkt;
  logic [ELEM_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic [4:0]               out_idx;
  modport master (output vec_feature, vec_feature_v, vec_mode, n_pkt, out_ready,
                  input  out_data, out_valid, out_last, out_idx);
  modport slave  (input  vec_feature, vec_feature_v, vec_mode, n_pkt, out_ready,
                  output out_data, out_valid, out_last, out_idx);
endinterface

// File: rtl/vec_feature_serializer.sv
// vec_feature_serializer: buffers up to two captured vectors and streams their elements one byte per beat
module vec_feature_serializer #(
  parameter int ELEM_W    = 8,
  parameter int N_ELEM    = 20,
  parameter int HALF_ELEM = 10
) (
  input  logic        clk,
  input  logic        rst,
  vec_feature_if.slave vf,
  output logic        busy,
  output logic        ovf_err,
  output logic [7:0]  drop_cnt
);
  localparam int VW = ELEM_W*N_ELEM;
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_n;
  logic [VW-1:0] vec_q [2];
  logic [4:0]    len_q [2];
  logic          rd, wr;
  logic [1:0]    cnt, cnt_n;
  logic [4:0]    idx, len_c;
  logic          cap, beat, last, pop, push, drop;
  always_comb begin
    len_c = vf.vec_mode == 2'b11 ? (vf.n_pkt > 8'(HALF_ELEM) ? 5'(HALF_ELEM) : vf.n_pkt[4:0])
                                 : (vf.n_pkt > 8'(N_ELEM) ? 5'(N_ELEM) : vf.n_pkt[4:0]);
    cap   = vf.vec_feature_v & |vf.vec_mode & |vf.n_pkt;
    beat  = vf.out_valid & vf.out_ready;
    last  = idx == len_q[rd] - 5'd1;
    pop   = beat & last;
    // a full buffer still accepts when the head drains in the same cycle
    push  = cap & (cnt != 2'd2 | pop);
    drop  = cap & ~push;
    cnt_n = 2'(cnt + {1'b0, push} - {1'b0, pop});
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rd       <= 1'b0;
      wr       <= 1'b0;
      idx      <= '0;
      ovf_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (push) begin
        vec_q[wr] <= vf.vec_feature;
        len_q[wr] <= len_c;
        wr        <= ~wr;
      end
      if (pop) rd <= ~rd;
      if (beat) idx <= last ? 5'd0 : idx + 5'd1;
      if (drop) begin
        ovf_err  <= 1'b1;
        drop_cnt <= drop_cnt + {7'd0, drop_cnt != 8'hFF};
      end
    end
  end
  always_comb state_n = cnt_n != 2'd0 ? STREAM : IDLE;
  always_comb begin
    vf.out_valid = state == STREAM;
    vf.out_data  = vf.out_valid ? vec_q[rd][idx*ELEM_W +: ELEM_W] : '0;
    vf.out_last  = vf.out_valid & last;
    vf.out_idx   = vf.out_valid ? idx : 5'd0;
    busy         = cnt != 2'd0;
  end
endmodule

// File: doc/vec_feature_serializer.md
Name: vec_feature_serializer

Overview:
- Consumer end of the vector-feature interface: captures each 160-bit vec_feature word (20 x 8-bit elements) on its single-cycle valid pulse.
- Streams the valid elements out one byte per beat over a valid/ready handshake toward the inference-engine input stage.
- The producer has no backpressure, so the block holds a 2-entry vector buffer and flags overflow.

Parameters:
- ELEM_W, 8, element width in bits.
- N_ELEM, 20, elements per vector word (vec_feature width = ELEM_W*N_ELEM).
- HALF_ELEM, 10, elements per half-vector in split mode (vec_mode 11).

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- vec_feature  in  160  element i at bits [8i+7:8i].
- vec_feature_v  in  1  one-cycle capture pulse, no ready.
- vec_mode  in  2  00 off, 01/10 full vector, 11 split; sampled with vec_feature_v.
- n_pkt  in  8  element count; sampled with vec_feature_v.
- out_data  out  8  current element.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- out_last  out  1  final element of the current vector.
- out_idx  out  5  element index of out_data.
- busy  out  1  buffer non-empty.
- ovf_err  out  1  sticky overflow flag.
- drop_cnt  out  8  saturating count of dropped vectors.

Behaviour:
- Reset (rst=1 at posedge): buffer emptied, state IDLE, idx=0; out_valid, out_last, busy, ovf_err = 0; out_data, out_idx = 0; drop_cnt = 0. Reset mid-stream discards all buffered vectors with no further beats.
- Length on capture, len (5 bits):
  - Modes 01/10: len = min(n_pkt, 20).
  - Mode 11: len = min(n_pkt, 10); only elements 0..9 are sent.
  - vec_mode=00 or n_pkt=0: vector ignored. No store, no drop count, no error.
- Buffer: 2-entry FIFO of {vector[159:0], len}, entry count 0..2.
  - Capture when vec_feature_v=1 and the vector is not ignored.
  - Store if count<2, or if count==2 and the head's last beat completes in the same cycle.
  - Otherwise drop: ovf_err set (sticky until rst); drop_cnt increments, saturating at 255.
- Handshake: beat completes when out_valid & out_ready.
  - out_data, out_last and out_idx are registered and held stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a completed beat.
- FSM:
  - IDLE: out_valid=0. Go to STREAM the cycle after the buffer becomes non-empty. First beat appears 1 cycle after the capture pulse.
  - STREAM: out_data = head.vector[idx]; out_last = (idx == len-1).
    - Non-last beat: idx+1.
    - Last beat: pop head, idx=0. If another entry is present (including one captured the same cycle into the freed slot), its element 0 is presented the next cycle with no bubble; otherwise go to IDLE.
- Simultaneous capture and pop with count==1: count stays 1; the new entry becomes head next cycle.
- len=1: the single beat has out_last=1.
- busy = (count != 0).

Test Plan:
- Mode 01, n_pkt=5, vec_feature bytes 0x01..0x14, out_ready=1 -> 5 beats 0x01..0x05 on consecutive cycles starting 1 cycle after the pulse, out_last only on 0x05, then IDLE.
- Mode 11, n_pkt=15, bytes 0xA0..0xB3 -> 10 beats 0xA0..0xA9, out_last on 0xA9.
- Mode 01, n_pkt=3, out_ready toggled 1,0,0,1,... -> each element held stable while stalled; sequence complete with no duplicates or losses.
- out_ready=0; three pulses (n_pkt=2 each) -> first two stored, third dropped: ovf_err=1, drop_cnt=1. Release out_ready -> 4 beats back-to-back, out_last on beats 2 and 4.
- Full buffer; third pulse in the same cycle as the head's last-beat acceptance -> no overflow, 3 vectors streamed. Separately, vec_mode=00 or n_pkt=0 -> no output, drop_cnt unchanged.
- rst asserted mid-stream at idx=2 -> next cycle out_valid=0, busy=0, ovf_err=0, drop_cnt=0; a new pulse restarts at idx=0.
